// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: reset PC default,
// word widths, fetch FSM encoding and the buffered fetch entry layout.
package fetch_unit_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned INSTR_W = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    FETCH_IDLE = 1'b0,
    FETCH_REQ  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; the head is presented combinationally
// and reads as zero while empty.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = ENTRY_W,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             I_clk,
  input  logic             I_reset_n,
  input  logic             I_flush,
  input  logic             I_push,
  input  logic             I_pop,
  input  logic [WIDTH-1:0] I_data,
  output logic [WIDTH-1:0] O_data,
  output logic [CNT_W-1:0] O_count,
  output logic             O_full,
  output logic             O_empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (I_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Power-of-two depth lets the pointers wrap by plain overflow.
      if (I_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (I_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(I_push) - CNT_W'(I_pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge I_clk) begin
    if (!I_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; count and pointers alone define which entries are live.
  always_ff @(posedge I_clk) begin
    if (I_push) mem_q[wr_ptr_q] <= I_data;
  end

  assign O_empty = (count_q == '0);
  assign O_full  = (count_q == CNT_W'(DEPTH));
  assign O_count = count_q;
  assign O_data  = O_empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding bus read FSM, redirect
// handling with drop of stale responses, and a buffer towards the decoder.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        I_clk,
  input  logic        I_reset_n,
  output logic        O_bus_req,
  output logic [31:0] O_bus_addr,
  input  logic        I_bus_ack,
  input  logic [31:0] I_bus_data,
  input  logic        I_redirect,
  input  logic [31:0] I_redirect_pc,
  output logic [31:0] O_instr,
  output logic [31:0] O_pc,
  output logic        O_valid,
  input  logic        I_ready,
  output logic        O_misaligned
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t     state_q, state_d;
  logic [31:0]      pc_q, pc_d;        // next address to request
  logic [31:0]      addr_q, addr_d;    // address of the request on the bus
  logic             drop_q, drop_d;
  logic             misaligned_q, misaligned_d;

  logic             acked, push, pop, can_issue;
  logic [31:0]      base_pc;
  logic [CNT_W-1:0] fifo_count, count_after;
  logic             fifo_full, fifo_empty;
  fetch_entry_t     push_entry, head_entry;

  assign pop        = !fifo_empty && I_ready;
  assign push_entry = '{pc: addr_q, instr: I_bus_data};

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    addr_d       = addr_q;
    drop_d       = drop_q;
    misaligned_d = misaligned_q;
    base_pc      = pc_q;

    acked = (state_q == FETCH_REQ) && I_bus_ack;
    push  = acked && !drop_q && !I_redirect && (!fifo_full || pop);

    if (I_redirect) begin
      base_pc      = align_word(I_redirect_pc);
      pc_d         = base_pc;
      misaligned_d = (I_redirect_pc[1:0] != 2'b00);
      // The pending request must still finish on the bus; its data is stale.
      if (state_q == FETCH_REQ && !I_bus_ack) drop_d = 1'b1;
    end

    count_after = I_redirect ? '0 : fifo_count + CNT_W'(push) - CNT_W'(pop);
    can_issue   = (count_after < CNT_W'(FIFO_DEPTH)) && !misaligned_d;

    case (state_q)
      FETCH_IDLE: begin
        if (can_issue) begin
          state_d = FETCH_REQ;
          addr_d  = base_pc;
          pc_d    = base_pc + 32'd4;
        end
      end
      FETCH_REQ: begin
        if (acked) begin
          drop_d = 1'b0;
          if (can_issue) begin
            addr_d = base_pc;
            pc_d   = base_pc + 32'd4;
          end else begin
            state_d = FETCH_IDLE;
          end
        end
      end
      default: state_d = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (!I_reset_n) begin
      state_q      <= FETCH_IDLE;
      pc_q         <= RESET_PC;
      addr_q       <= '0;
      drop_q       <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      addr_q       <= addr_d;
      drop_q       <= drop_d;
      misaligned_q <= misaligned_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .I_clk     (I_clk),
    .I_reset_n (I_reset_n),
    .I_flush   (I_redirect),
    .I_push    (push),
    .I_pop     (pop),
    .I_data    (push_entry),
    .O_data    (head_entry),
    .O_count   (fifo_count),
    .O_full    (fifo_full),
    .O_empty   (fifo_empty)
  );

  assign O_bus_req    = (state_q == FETCH_REQ);
  assign O_bus_addr   = addr_q;
  assign O_valid      = !fifo_empty;
  assign O_instr      = head_entry.instr;
  assign O_pc         = head_entry.pc;
  assign O_misaligned = misaligned_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: cycle-exact vector table, directed
// redirect/reset sequences, and a randomized run against a transaction model.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h100;
  localparam int          DEPTH  = 2;

  logic        I_clk, I_reset_n;
  logic        O_bus_req;
  logic [31:0] O_bus_addr;
  logic        I_bus_ack;
  logic [31:0] I_bus_data;
  logic        I_redirect;
  logic [31:0] I_redirect_pc;
  logic [31:0] O_instr, O_pc;
  logic        O_valid, I_ready, O_misaligned;

  fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .I_clk         (I_clk),
    .I_reset_n     (I_reset_n),
    .O_bus_req     (O_bus_req),
    .O_bus_addr    (O_bus_addr),
    .I_bus_ack     (I_bus_ack),
    .I_bus_data    (I_bus_data),
    .I_redirect    (I_redirect),
    .I_redirect_pc (I_redirect_pc),
    .O_instr       (O_instr),
    .O_pc          (O_pc),
    .O_valid       (O_valid),
    .I_ready       (I_ready),
    .O_misaligned  (O_misaligned)
  );

  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  int checks = 0;
  int errors = 0;
  int delivered = 0;

  // Transaction-level model: words the decoder should see, plus the bus view.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t        mq[$];
  bit          outstanding, stale, mis, exp_req;
  logic [31:0] out_addr, exp_next;

  typedef struct packed {
    bit          rdy;
    bit          ack;
    bit          redir;
    logic [31:0] rpc;
    bit          exp_req;
    logic [31:0] exp_addr;
    bit          exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    outstanding = 1'b0;
    stale       = 1'b0;
    mis         = 1'b0;
    exp_req     = 1'b0;
    exp_next    = RST_PC;
    out_addr    = '0;
  endtask

  // A new request appears right after an edge at which the bench expected one.
  task automatic model_sample();
    if (exp_req && !outstanding) begin
      outstanding = 1'b1;
      out_addr    = exp_next;
      exp_next    = exp_next + 32'd4;
      stale       = 1'b0;
    end
  endtask

  task automatic check_outputs();
    check("bus_req", {31'b0, O_bus_req}, {31'b0, exp_req});
    if (exp_req) check("bus_addr", O_bus_addr, out_addr);
    check("valid", {31'b0, O_valid}, {31'b0, mq.size() != 0});
    if (mq.size() != 0) begin
      check("pc", O_pc, mq[0].pc);
      check("instr", O_instr, mq[0].instr);
    end
    check("misaligned", {31'b0, O_misaligned}, {31'b0, mis});
  endtask

  task automatic step(input bit rdy, input bit ack, input bit redir, input logic [31:0] rpc);
    bit do_ack;
    I_ready       = rdy;
    I_bus_ack     = ack;
    I_bus_data    = ack ? word_of(O_bus_addr) : 32'h0;
    I_redirect    = redir;
    I_redirect_pc = rpc;
    do_ack        = ack && outstanding;

    if (rdy && mq.size() != 0) begin
      mq.delete(0);
      delivered++;
    end
    if (redir) begin
      mq.delete();
      exp_next = {rpc[31:2], 2'b00};
      mis      = (rpc[1:0] != 2'b00);
      if (outstanding && !do_ack) stale = 1'b1;
    end else if (do_ack && !stale) begin
      mq.push_back('{pc: out_addr, instr: word_of(out_addr)});
    end
    if (do_ack) begin
      outstanding = 1'b0;
      stale       = 1'b0;
    end
    exp_req = outstanding ? 1'b1 : (mq.size() < DEPTH && !mis);

    @(posedge I_clk);
    #1;
    I_bus_ack  = 1'b0;
    I_redirect = 1'b0;
    model_sample();
    check_outputs();
  endtask

  task automatic do_reset();
    I_reset_n  = 1'b0;
    I_ready    = 1'b0;
    I_bus_ack  = 1'b0;
    I_redirect = 1'b0;
    @(posedge I_clk);
    #1;
    I_reset_n = 1'b1;
    model_reset();
  endtask

  // Acks requests with ready high until a request for addr is pending.
  task automatic reach(input logic [31:0] addr);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (outstanding && out_addr == addr) begin
        found = 1'b1;
        break;
      end
      step(1'b1, outstanding, 1'b0, 32'h0);
    end
    check("reach_addr", {31'b0, found}, 32'd1);
  endtask

  vec_t        tbl[7];
  logic [31:0] rpc;
  bit          rdy, ack, redir;

  initial begin
    I_reset_n = 1'b0; I_bus_ack = 1'b0; I_bus_data = '0;
    I_redirect = 1'b0; I_redirect_pc = '0; I_ready = 1'b0;

    // rdy ack redir rpc | exp_req exp_addr exp_valid exp_pc
    tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h104, 1'b1, 32'h100};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h108, 1'b1, 32'h104};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,   1'b1, 32'h104};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,   1'b1, 32'h104};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h10C, 1'b1, 32'h108};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h10C, 1'b0, 32'h0};

    // Reset state.
    do_reset();
    check("rst_req", {31'b0, O_bus_req}, 32'd0);
    check("rst_valid", {31'b0, O_valid}, 32'd0);
    check("rst_mis", {31'b0, O_misaligned}, 32'd0);
    check("rst_instr", O_instr, 32'd0);
    check("rst_pc", O_pc, 32'd0);

    // Cycle-exact streaming, back-pressure and resume.
    foreach (tbl[i]) begin
      step(tbl[i].rdy, tbl[i].ack, tbl[i].redir, tbl[i].rpc);
      check($sformatf("tbl%0d_req", i), {31'b0, O_bus_req}, {31'b0, tbl[i].exp_req});
      if (tbl[i].exp_req) check($sformatf("tbl%0d_addr", i), O_bus_addr, tbl[i].exp_addr);
      check($sformatf("tbl%0d_valid", i), {31'b0, O_valid}, {31'b0, tbl[i].exp_valid});
      if (tbl[i].exp_valid) check($sformatf("tbl%0d_pc", i), O_pc, tbl[i].exp_pc);
    end

    // Decoder stalled for 10 cycles: buffer fills to depth, then the bus goes quiet.
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b0, outstanding, 1'b0, 32'h0);
    check("stall_req", {31'b0, O_bus_req}, 32'd0);
    check("stall_head", O_pc, 32'h100);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check("resume_head", O_pc, 32'h104);
    check("resume_addr", O_bus_addr, 32'h108);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check("resume_drain", {31'b0, O_valid}, 32'd0);

    // Redirect while a request is waiting; its late ack must be dropped.
    do_reset();
    reach(32'h10C);
    step(1'b1, 1'b0, 1'b1, 32'h200);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check("drop_addr_held", O_bus_addr, 32'h10C);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("drop_valid", {31'b0, O_valid}, 32'd0);
    check("drop_next_addr", O_bus_addr, 32'h200);

    // Redirect in the same cycle as an ack.
    do_reset();
    reach(32'h110);
    step(1'b1, 1'b1, 1'b1, 32'h300);
    check("same_cyc_valid", {31'b0, O_valid}, 32'd0);
    check("same_cyc_req", {31'b0, O_bus_req}, 32'd1);
    check("same_cyc_addr", O_bus_addr, 32'h300);

    // Misaligned target halts fetch until an aligned redirect.
    step(1'b1, 1'b1, 1'b1, 32'h402);
    check("mis_set", {31'b0, O_misaligned}, 32'd1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    check("mis_halt", {31'b0, O_bus_req}, 32'd0);
    step(1'b1, 1'b0, 1'b1, 32'h500);
    check("mis_clear", {31'b0, O_misaligned}, 32'd0);
    check("mis_resume", O_bus_addr, 32'h500);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("mis_first_pc", O_pc, 32'h500);

    // Reset mid-request followed by an ack the DUT must ignore.
    do_reset();
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("rst_ack_valid", {31'b0, O_valid}, 32'd0);
    check("rst_ack_addr", O_bus_addr, RST_PC);

    // Randomized traffic against the model.
    delivered = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
        check_outputs();
      end
      rdy   = ($urandom_range(0, 3) != 0);
      ack   = outstanding && ($urandom_range(0, 2) != 0);
      redir = ($urandom_range(0, 24) == 0);
      rpc   = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      if ($urandom_range(0, 5) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
      step(rdy, ack, redir, rpc);
    end
    check("progress", {31'b0, delivered > 200}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the decoder.
- Holds the PC and issues word reads on the instruction bus.
- Buffers returned instruction words in a small FIFO and presents them, together with their PC, to the decoder under a valid/ready handshake.
- Accepts PC redirects from the execute/branch stage and flushes stale state.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FIFO_DEPTH, 2, instruction buffer entries; power of two, minimum 2.

Ports:
- I_clk  in  1  clock; all state updates on rising edge.
- I_reset_n  in  1  synchronous active-low reset, sampled on rising edge of I_clk.
- O_bus_req  out  1  read request; held until acknowledged.
- O_bus_addr  out  32  word-aligned fetch address; bits [1:0] always 0.
- I_bus_ack  in  1  single-cycle acknowledge; data valid in the same cycle.
- I_bus_data  in  32  instruction word returned with ack.
- I_redirect  in  1  one-cycle pulse requesting a PC change (taken branch, jump, trap).
- I_redirect_pc  in  32  new PC; valid while I_redirect is high.
- O_instr  out  32  instruction word to decoder; feeds decoder I_instr.
- O_pc  out  32  PC of O_instr.
- O_valid  out  1  O_instr/O_pc valid.
- I_ready  in  1  decoder accepts this cycle; drives decoder I_en via the pipeline controller.
- O_misaligned  out  1  sticky flag: redirect target had bits [1:0] != 0.

Behaviour:
- Reset (I_reset_n low at a clock edge):
  - fetch_pc = RESET_PC; FIFO empty; state = IDLE.
  - O_bus_req = 0, O_valid = 0, O_misaligned = 0.
  - O_instr = 0, O_pc = 0.
  - Reset mid-transaction abandons the request; any I_bus_ack in the following cycle is ignored because state is IDLE.
- FSM states:
  - IDLE: if FIFO has a free slot (count + in-flight < FIFO_DEPTH) and O_misaligned == 0 -> REQ.
  - REQ: O_bus_req = 1, O_bus_addr = fetch_pc.
    - On I_bus_ack: if drop == 0, push {fetch_pc, I_bus_data}.
    - Then fetch_pc += 4; clear drop.
    - Next state is REQ if space remains after this cycle's push/pop, else IDLE.
  - No other states. One outstanding request at a time.
- Request rules:
  - O_bus_addr and O_bus_req are stable while waiting for ack.
  - O_bus_req rises no earlier than one cycle after entering REQ from IDLE.
  - Sustained throughput is one word per cycle when the bus acks every cycle and I_ready = 1.
- FIFO:
  - Head drives O_instr/O_pc combinationally; O_valid = !empty.
  - Pop when O_valid && I_ready.
  - Simultaneous push and pop when full: pop first, then push; count unchanged.
  - Push when full without pop never occurs, guaranteed by the space check.
  - Pointers wrap modulo FIFO_DEPTH.
  - Latency from ack to O_valid is one cycle: the word is registered into the FIFO.
- Redirect (I_redirect = 1), highest priority after reset:
  - FIFO flushed; O_valid = 0 next cycle.
  - fetch_pc = {I_redirect_pc[31:2], 2'b00}.
  - If a request is pending in REQ and not acked this cycle, it is completed on the bus but its data is dropped (drop = 1). O_bus_addr is not changed mid-request.
  - If acked in the same cycle, the acked data is discarded.
  - Any pop in the same cycle still counts as accepted by the decoder.
  - If I_redirect_pc[1:0] != 0: O_misaligned set and fetching halts in IDLE until the next redirect with an aligned target, which clears the flag.
- Invariants:
  - O_valid never asserted for a word fetched before the latest redirect.
  - The PC sequence is strictly +4 between redirects.

Decomposition:
- Shared package (riscvdefs.vh): RESET_PC default, instruction width constant, fetch FSM state encodings FETCH_IDLE/FETCH_REQ.
- One natural sub-module: fetch_fifo — synchronous parameterised FIFO with flush, push, pop, count, and full/empty outputs.
- fetch_unit instantiates fetch_fifo and holds the FSM, PC, and drop flag.

Test Plan:
- Reset with RESET_PC = 32'h100, bus acks every cycle, I_ready = 1 -> addresses 0x100, 0x104, 0x108...; O_pc follows one cycle after each ack, with O_instr matching the bus data.
- I_ready = 0 for 10 cycles -> exactly FIFO_DEPTH (2) words buffered, then O_bus_req = 0. Raise I_ready -> words 0x100 and 0x104 delivered in order, and fetch resumes at 0x108.
- I_redirect to 0x200 while a request for 0x10C is waiting, ack arriving 3 cycles later -> 0x10C data never appears on O_valid; next address 0x200.
- I_redirect to 0x300 in the same cycle as an ack for 0x110 -> 0x110 dropped, FIFO empty next cycle, next request at 0x300.
- I_redirect to 0x402 -> O_misaligned = 1, O_bus_req stays 0. A later redirect to 0x500 clears the flag and fetch resumes at 0x500.
- Pull I_reset_n low for one cycle mid-request, bus then acks -> ack ignored, O_valid = 0, next request at RESET_PC.
